// File: rtl/pixel_writer_if.sv
// Pixel-side handshake and Avalon-MM-style write master bundle for pixel_writer.
// The master modport is the view of pixel_writer itself. The slave modport is
// the view of its surroundings: the line stepper and the SDRAM slave.
interface pixel_writer_if;
  logic        pix_valid;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [31:0] pix_color;
  logic        pix_ready;
  logic [31:0] fb_base;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic        busy;
  logic [15:0] clip_count;

  modport master (
    input  pix_valid, pix_x, pix_y, pix_color, fb_base, mem_waitrequest,
    output pix_ready, mem_address, mem_write, mem_writedata, busy, clip_count
  );

  modport slave (
    output pix_valid, pix_x, pix_y, pix_color, fb_base, mem_waitrequest,
    input  pix_ready, mem_address, mem_write, mem_writedata, busy, clip_count
  );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer: clips incoming (x, y) pixels against the screen and converts
// each surviving pixel to a framebuffer byte address. The result is queued in
// a small write FIFO and issued as single-beat writes.
// Pipeline: S1 captures the pixel and clip-tests it. S2 holds the row offset.
// The FIFO push follows S2. pix_ready counts every slot already spoken for, so
// the pipeline never has to stall.
module pixel_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BPP_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  pixel_writer_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = CW + 1;
  localparam logic [31:0] SCREEN_W_U = 32'(SCREEN_W);
  localparam logic [31:0] SCREEN_H_U = 32'(SCREEN_H);

  // Stage S1
  logic        s1_valid_r;
  logic [15:0] s1_x_r;
  logic [15:0] s1_y_r;
  logic [31:0] s1_color_r;
  logic [31:0] s1_base_r;
  // Stage S2
  logic        s2_valid_r;
  logic [31:0] s2_row_off_r;
  logic [15:0] s2_x_r;
  logic [31:0] s2_color_r;
  logic [31:0] s2_base_r;
  // Write FIFO
  logic [31:0] addr_mem_r [FIFO_DEPTH];
  logic [31:0] data_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   clip_count_r;

  logic          accept_s;
  logic          s1_clip_s;
  logic          s1_keep_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   push_addr_s;
  logic [IW-1:0] in_flight_s;

  // Clipping uses an unsigned compare, so negative coordinates (>= 32768) are clipped too.
  assign s1_clip_s   = ({16'h0000, s1_x_r} >= SCREEN_W_U) || ({16'h0000, s1_y_r} >= SCREEN_H_U);
  assign s1_keep_s   = s1_valid_r & ~s1_clip_s;
  assign in_flight_s = IW'(count_r) + IW'(s1_valid_r) + IW'(s2_valid_r);
  assign bus.pix_ready = n_rst & (in_flight_s < IW'(FIFO_DEPTH));
  assign accept_s    = bus.pix_valid & bus.pix_ready;
  assign push_s      = s2_valid_r;
  assign pop_s       = bus.mem_write & ~bus.mem_waitrequest;
  assign push_addr_s = s2_base_r + ((s2_row_off_r + {16'h0000, s2_x_r}) << BPP_LOG2);

  assign bus.mem_write     = (count_r != {CW{1'b0}});
  assign bus.mem_address   = addr_mem_r[rd_ptr_r];
  assign bus.mem_writedata = data_mem_r[rd_ptr_r];
  assign bus.busy          = s1_valid_r | s2_valid_r | (count_r != {CW{1'b0}});
  assign bus.clip_count    = clip_count_r;

  // Capture accepted pixels into S1, and move unclipped pixels into S2 with their row offset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_valid_r   <= 1'b0;
      s1_x_r       <= 16'h0000;
      s1_y_r       <= 16'h0000;
      s1_color_r   <= 32'h0000_0000;
      s1_base_r    <= 32'h0000_0000;
      s2_valid_r   <= 1'b0;
      s2_row_off_r <= 32'h0000_0000;
      s2_x_r       <= 16'h0000;
      s2_color_r   <= 32'h0000_0000;
      s2_base_r    <= 32'h0000_0000;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_x_r     <= bus.pix_x;
        s1_y_r     <= bus.pix_y;
        s1_color_r <= bus.pix_color;
        s1_base_r  <= bus.fb_base;
      end
      s2_valid_r <= s1_keep_s;
      if (s1_keep_s) begin
        s2_row_off_r <= {16'h0000, s1_y_r} * SCREEN_W_U;
        s2_x_r       <= s1_x_r;
        s2_color_r   <= s1_color_r;
        s2_base_r    <= s1_base_r;
      end
    end
  end

  // Count pixels dropped by clipping; the count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      clip_count_r <= 16'h0000;
    end else if (s1_valid_r && s1_clip_s && (clip_count_r != 16'hFFFF)) begin
      clip_count_r <= clip_count_r + 16'h0001;
    end else begin
      clip_count_r <= clip_count_r;
    end
  end

  // Run the write FIFO. The head entry is the bus output and holds while waitrequest is high.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_r[i] <= 32'h0000_0000;
        data_mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= push_addr_s;
        data_mem_r[wr_ptr_r] <= s2_color_r;
        wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: a driver issues directed and random pixels and
// queues the writes expected from screen geometry. A monitor compares every
// write the DUT completes against that queue.
module tb_pixel_writer;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  pixel_writer_if bus ();

  pixel_writer #(
    .SCREEN_W(640), .SCREEN_H(480), .BPP_LOG2(2), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];
  int clip_exp = 0;
  int writes_seen = 0;
  logic held = 1'b0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] held_data = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: clip against 640x480, otherwise address = base + 4*(y*640 + x).
  task automatic model_accept(input logic [15:0] x, input logic [15:0] y,
                              input logic [31:0] c, input logic [31:0] base);
    logic [31:0] idx;
    if (x >= 16'd640 || y >= 16'd480) begin
      if (clip_exp < 65535) clip_exp++;
    end else begin
      idx = 32'(y) * 32'd640 + 32'(x);
      exp_q.push_back({base + idx * 32'd4, c});
    end
  endtask

  // Present one pixel until it is accepted. The caller is just past a rising edge, and so is the return.
  task automatic send_pixel(input logic [15:0] x, input logic [15:0] y,
                            input logic [31:0] c, input logic [31:0] base, output int stalls);
    stalls = 0;
    bus.pix_valid = 1'b1;
    bus.pix_x = x; bus.pix_y = y; bus.pix_color = c; bus.fb_base = base;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) begin
        model_accept(x, y, c, base);
        @(posedge clk); #1;
        break;
      end
      stalls++;
      if (stalls > 200) begin
        check("accept_timeout", 64'(stalls), 64'd0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    check("drain_busy", 64'(bus.busy), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_write(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.mem_write && n < 20) begin
      @(negedge clk); n++;
    end
    check(name, 64'(bus.mem_address), 64'(exp_addr));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    exp_q.delete();
    clip_exp = 0;
    @(negedge clk);
    check("rst_ready_low", 64'(bus.pix_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_clip", 64'(bus.clip_count), 64'd0);
    check("rst_addr", 64'(bus.mem_address), 64'd0);
    check("rst_data", 64'(bus.mem_writedata), 64'd0);
    n_rst = 1'b1;
  endtask

  // Monitor: score each completed write, and check that the head holds steady while stalled.
  always @(negedge clk) begin
    if (n_rst !== 1'b1) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        check("stall_addr_stable", 64'(bus.mem_address), 64'(held_addr));
        check("stall_data_stable", 64'(bus.mem_writedata), 64'(held_data));
      end
      if (bus.mem_write) begin
        if (!bus.mem_waitrequest) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.mem_address, bus.mem_writedata}, 64'd0);
          end else begin
            check("write", {bus.mem_address, bus.mem_writedata}, exp_q.pop_front());
          end
          held <= 1'b0;
        end else begin
          held <= 1'b1;
          held_addr <= bus.mem_address;
          held_data <= bus.mem_writedata;
        end
      end else begin
        held <= 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    int tot;
    int w0;
    bit done;
    n_rst = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_x = 16'h0; bus.pix_y = 16'h0;
    bus.pix_color = 32'h0; bus.fb_base = 32'h0; bus.mem_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_ready", 64'(bus.pix_ready), 64'd0);
    check("init_mem_write", 64'(bus.mem_write), 64'd0);
    check("init_busy", 64'(bus.busy), 64'd0);
    check("init_clip", 64'(bus.clip_count), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Single pixel: latency and address
    send_pixel(16'd10, 16'd2, 32'hFF00FF00, 32'h1000_0000, st);
    @(negedge clk); check("lat_c1", 64'(bus.mem_write), 64'd0);
    @(negedge clk); check("lat_c2", 64'(bus.mem_write), 64'd0);
    @(negedge clk); check("lat_c3", 64'(bus.mem_write), 64'd1);
    check("single_addr", 64'(bus.mem_address), 64'h1000_1428);
    check("single_data", 64'(bus.mem_writedata), 64'hFF00FF00);
    @(negedge clk); check("lat_c4", 64'(bus.mem_write), 64'd0);
    check("single_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // Clipping
    send_pixel(16'd640, 16'd0, 32'h1, 32'h0, st);
    send_pixel(16'd0, 16'd480, 32'h2, 32'h0, st);
    send_pixel(16'hFFFF, 16'd5, 32'h3, 32'h0, st);
    drain();
    check("clip_count_3", 64'(bus.clip_count), 64'd3);
    send_pixel(16'd639, 16'd479, 32'h0BADCAFE, 32'h2000_0000, st);
    wait_write("corner_addr", 32'h2012_BFFC);
    drain();

    // Backpressure: 4 fill the pipe, the rest wait for waitrequest release
    bus.mem_waitrequest = 1'b1;
    w0 = writes_seen;
    for (int i = 0; i < 4; i++)
      send_pixel(16'(i * 7), 16'(i), $urandom, 32'h3000_0000, st);
    repeat (3) begin
      @(negedge clk); check("bp_ready_low", 64'(bus.pix_ready), 64'd0);
    end
    @(posedge clk); #1;
    fork
      for (int i = 4; i < 8; i++)
        send_pixel(16'(i * 7), 16'(i), $urandom, 32'h3000_0000, st);
      begin
        repeat (4) @(posedge clk);
        #1 bus.mem_waitrequest = 1'b0;
      end
    join
    drain();
    check("bp_write_count", 64'(writes_seen - w0), 64'd8);

    // Sustained throughput with no waitrequest
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      send_pixel(16'(i), 16'd100, $urandom, 32'h4000_0000, st);
      tot += st;
      if (i >= 2) check("stream_write_each_cycle", 64'(bus.mem_write), 64'd1);
    end
    check("stream_no_stall", 64'(tot), 64'd0);
    drain();

    // Address wrap
    send_pixel(16'd8, 16'd0, 32'h12345678, 32'hFFFF_FFF0, st);
    wait_write("wrap_addr", 32'h0000_0010);
    drain();

    // Randomized traffic with random waitrequest
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [15:0] rx;
          logic [15:0] ry;
          rx = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 700));
          ry = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 520));
          send_pixel(rx, ry, $urandom, $urandom, st);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.mem_waitrequest = ($urandom_range(0, 2) == 0);
        end
        bus.mem_waitrequest = 1'b0;
      end
    join
    drain();
    check("random_clip_count", 64'(bus.clip_count), 64'(clip_exp));

    // Reset with writes pending
    bus.mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++)
      send_pixel(16'(i + 1), 16'd3, $urandom, 32'h5000_0000, st);
    repeat (3) @(negedge clk);
    check("pending_mem_write", 64'(bus.mem_write), 64'd1);
    w0 = writes_seen;
    do_reset();
    bus.mem_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check("no_stale_write", 64'(writes_seen - w0), 64'd0);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Downstream consumer of the line-stepping stage: takes one (x, y) pixel per handshake plus a colour.
- Clips it against the screen, converts it to a framebuffer byte address and buffers it.
- Issues single-beat writes on an Avalon-MM-style master port towards SDRAM.
- Its ready output drives the line stepper's get_pixel request, so the stepper advances only when a pixel has been accepted.

Parameters:
- SCREEN_W, 640, visible width in pixels; must be > 0.
- SCREEN_H, 480, visible height in pixels; must be > 0.
- BPP_LOG2, 2, log2 of bytes per pixel; byte offset = pixel index << BPP_LOG2.
- FIFO_DEPTH, 4, write buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  synchronous active-low reset
- pix_valid  in  1  pixel presented by line stage
- pix_x  in  16  pixel column, unsigned (two's-complement negatives appear as >= 32768)
- pix_y  in  16  pixel row, unsigned
- pix_color  in  32  pixel data
- pix_ready  out  1  pixel accepted this cycle when pix_valid & pix_ready (feeds get_pixel)
- fb_base  in  32  framebuffer byte base address, sampled per pixel at acceptance
- mem_address  out  32  write byte address
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_waitrequest  in  1  slave stall
- busy  out  1  any pixel in pipeline or FIFO
- clip_count  out  16  number of clipped pixels, saturating

Behaviour:
- Reset (n_rst low at a clk edge):
  - Pipeline valids, FIFO pointers/count and clip_count cleared.
  - mem_write=0, mem_address=0, mem_writedata=0, busy=0.
  - pix_ready=0 while n_rst is low.
  - A reset mid-operation discards all pending writes; mem_write is low from the first cycle after the reset edge.
- Accept (edge A): pix_valid & pix_ready.
  - pix_x, pix_y, pix_color and fb_base are registered into stage S1.
  - Clip test in S1: clipped if pix_x >= SCREEN_W or pix_y >= SCREEN_H (unsigned compare).
- S1 -> S2 (edge A+1):
  - Clipped pixel: dropped and clip_count increments, saturating at 16'hFFFF.
  - Otherwise S2 holds row_off = pix_y * SCREEN_W as 32-bit, together with x, colour and base.
- S2 -> FIFO (edge A+2): push {fb_base + ((row_off + x) << BPP_LOG2), colour}. All arithmetic is 32-bit and wraps modulo 2^32.
- The pipeline never stalls internally.
  - pix_ready = (fifo_count + S1_valid + S2_valid) < FIFO_DEPTH, so a FIFO push never overflows.
  - Clipped entries still count as in flight while in S1.
- Memory side:
  - mem_write = FIFO non-empty; mem_address and mem_writedata are the FIFO head, driven from registers.
  - Pop on mem_write & !mem_waitrequest.
  - While mem_waitrequest=1, address and data hold stable and mem_write stays high.
- A push and pop in the same cycle leave the count unchanged; push to a full FIFO cannot occur.
- Latency: with no waitrequest, mem_write is first high in the cycle following edge A+2 (3 cycles after acceptance). Sustained throughput is 1 pixel/cycle.
- busy = S1_valid | S2_valid | (fifo_count != 0).
- Writes leave in acceptance order.

Test Plan:
- Reset, then a single pixel (x=10, y=2, colour=32'hFF00FF00, fb_base=32'h1000_0000), waitrequest=0 -> one write at address 32'h1000_1428 with data 32'hFF00FF00, mem_write high exactly 1 cycle, 3 cycles after acceptance; busy then returns to 0.
- Clipping: pixels (640,0), (0,480) and (16'hFFFF,5) -> no mem_write, clip_count=3. Then (639,479) -> write at base + 0x12BFFC.
- Backpressure: 8 back-to-back pixels with waitrequest held at 1 -> pix_ready falls once 4 are in flight and the head address/data stay stable. Releasing waitrequest -> all 8 written in order, no loss or duplicate.
- Simultaneous push/pop: continuous pixels with waitrequest=0 -> 1 write per cycle, pix_ready stays 1, FIFO count constant.
- Reset mid-burst: n_rst low for 1 cycle while 3 writes are pending -> mem_write=0 the next cycle, busy=0, clip_count=0, and no stale write after reset.
- Address wrap: fb_base=32'hFFFF_FFF0, pixel (8,0) -> mem_address=32'h0000_0010.
